// File: rtl/pow_seq_ctrl.sv
// Exponentiation sequencer: two round-robin requesters, one multiply per clock,
// saturating 8-bit result with overflow flag and req/ack/done handshakes.
module pow_seq_ctrl #(
    parameter int                W_IN    = 4,
    parameter int                W_OUT   = 8,
    parameter logic [W_OUT-1:0]  SAT_VAL = 8'hFF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_a,
    input  logic [W_IN-1:0]  base_a,
    input  logic [W_IN-1:0]  exp_a,
    input  logic             req_b,
    input  logic [W_IN-1:0]  base_b,
    input  logic [W_IN-1:0]  exp_b,
    output logic             ack_a,
    output logic             ack_b,
    output logic             busy,
    output logic             done_a,
    output logic             done_b,
    output logic [W_OUT-1:0] result,
    output logic             ovf
);

    localparam int PW = W_OUT + W_IN;

    typedef enum logic [1:0] {IDLE, MULT, DONE} state_t;

    state_t            state;
    logic              rr;
    logic              owner;
    logic [W_IN-1:0]   base_r;
    logic [W_IN-1:0]   cnt;
    logic [W_OUT-1:0]  acc;
    logic              ovf_int;

    logic              gnt_a;
    logic              gnt_b;
    logic [W_IN-1:0]   sel_base;
    logic [W_IN-1:0]   sel_exp;
    logic [PW-1:0]     prod;

    // rr=0 prefers A on contention, rr=1 prefers B
    assign gnt_a    = req_a && (!req_b || !rr);
    assign gnt_b    = req_b && (!req_a || rr);
    assign sel_base = gnt_b ? base_b : base_a;
    assign sel_exp  = gnt_b ? exp_b : exp_a;

    // full-width product so overflow is seen before any truncation
    assign prod = PW'(acc) * PW'(base_r);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            rr      <= 1'b0;
            owner   <= 1'b0;
            base_r  <= '0;
            cnt     <= '0;
            acc     <= '0;
            ovf_int <= 1'b0;
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            busy    <= 1'b0;
            done_a  <= 1'b0;
            done_b  <= 1'b0;
            result  <= '0;
            ovf     <= 1'b0;
        end else begin
            ack_a  <= 1'b0;
            ack_b  <= 1'b0;
            done_a <= 1'b0;
            done_b <= 1'b0;
            case (state)
                IDLE: begin
                    busy <= 1'b0;
                    if (gnt_a || gnt_b) begin
                        ack_a   <= gnt_a;
                        ack_b   <= gnt_b;
                        owner   <= gnt_b;
                        base_r  <= sel_base;
                        cnt     <= sel_exp;
                        ovf_int <= 1'b0;
                        if (req_a && req_b)
                            rr <= ~rr;
                        if (sel_base == '0) begin
                            acc   <= '0;
                            state <= DONE;
                        end else begin
                            acc   <= W_OUT'(1);
                            state <= (sel_exp == '0) ? DONE : MULT;
                        end
                    end
                end
                MULT: begin
                    busy <= 1'b1;
                    if (prod[PW-1:W_OUT] != '0) begin
                        ovf_int <= 1'b1;
                        acc     <= SAT_VAL;
                        state   <= DONE;
                    end else begin
                        acc <= prod[W_OUT-1:0];
                        cnt <= cnt - 1'b1;
                        if (cnt == W_IN'(1))
                            state <= DONE;
                    end
                end
                DONE: begin
                    busy   <= 1'b1;
                    result <= acc;
                    ovf    <= ovf_int;
                    done_a <= !owner;
                    done_b <= owner;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
